// File: rtl/edge_pulse_gen_if.sv
// Bundle of level inputs, controls and pulse/status outputs for edge_pulse_gen.
// master drives the inputs and observes the outputs; slave is the generator itself.
interface edge_pulse_gen_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 16
);

  logic [CH-1:0]    in;
  logic [1:0]       mode;
  logic             retrig;
  logic             clr;
  logic [CH-1:0]    pulse;
  logic [CH-1:0]    missed;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output in,
    output mode,
    output retrig,
    output clr,
    input  pulse,
    input  missed,
    input  evt_cnt
  );

  modport slave (
    input  in,
    input  mode,
    input  retrig,
    input  clr,
    output pulse,
    output missed,
    output evt_cnt
  );

endinterface

// File: rtl/edge_pulse_gen.sv
// Multi-channel level-to-pulse generator with optional input synchroniser and Moore/Mealy timing.
// Define EPG_EVT_CNT_EN to build the saturating detected-edge counter; otherwise evt_cnt is 0.
module edge_pulse_gen #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned MEALY       = 0,
  parameter int unsigned CNT_W       = 16
) (
  input logic             clk,
  input logic             reset,
  edge_pulse_gen_if.slave bus
);

  localparam int unsigned RemW = $clog2(PULSE_LEN + 1);
  localparam logic [RemW-1:0] LoadVal = (MEALY != 0) ? RemW'(PULSE_LEN - 1) : RemW'(PULSE_LEN);
  // A one-cycle Mealy pulse is fully covered by the detection cycle, so ACTIVE is never entered.
  localparam bit SkipActive = (MEALY != 0) && (PULSE_LEN == 1);

  typedef enum logic {
    StIdle,
    StActive
  } state_e;

  logic [CH-1:0]   s;
  logic [CH-1:0]   prev_q;
  logic [CH-1:0]   edge_det;
  logic [CH-1:0]   miss_set;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   missed_q;
  state_e          state_q [CH];
  state_e          state_d [CH];
  logic [RemW-1:0] rem_q   [CH];
  logic [RemW-1:0] rem_d   [CH];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = bus.in;
    end else begin : g_sync
      logic [CH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= bus.in;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= s;
  end

  // Edges are masked during reset so a Mealy pulse cannot escape while reset is held.
  always_comb begin
    edge_det = '0;
    case (bus.mode)
      2'b00:   edge_det = s & ~prev_q;
      2'b01:   edge_det = ~s & prev_q;
      2'b10:   edge_det = s ^ prev_q;
      default: edge_det = '0;
    endcase
    if (reset) edge_det = '0;
  end

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      state_d[i]  = state_q[i];
      rem_d[i]    = rem_q[i];
      miss_set[i] = 1'b0;
      pulse[i]    = 1'b0;
      unique case (state_q[i])
        StIdle: begin
          pulse[i] = (MEALY != 0) && edge_det[i];
          if (edge_det[i] && !SkipActive) begin
            state_d[i] = StActive;
            rem_d[i]   = LoadVal;
          end
        end
        StActive: begin
          pulse[i] = 1'b1;
          if (edge_det[i] && bus.retrig) begin
            rem_d[i] = LoadVal;
          end else begin
            miss_set[i] = edge_det[i];
            if (rem_q[i] == RemW'(1)) begin
              state_d[i] = StIdle;
              rem_d[i]   = '0;
            end else begin
              rem_d[i] = rem_q[i] - RemW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= StIdle;
        rem_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  // A miss in the same cycle as clr survives.
  always_ff @(posedge clk) begin
    if (reset) missed_q <= '0;
    else       missed_q <= (missed_q & ~{CH{bus.clr}}) | miss_set;
  end

  assign bus.pulse  = pulse;
  assign bus.missed = missed_q;

`ifdef EPG_EVT_CNT_EN
  localparam int unsigned SumW = CNT_W + 6;

  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       pop;
  logic [SumW-1:0]  sum;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < CH; i++) pop = pop + 6'(edge_det[i]);
    sum = (bus.clr ? '0 : SumW'(cnt_q)) + SumW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset)                                 cnt_q <= '0;
    else if (sum > SumW'({CNT_W{1'b1}}))       cnt_q <= '1;
    else                                       cnt_q <= sum[CNT_W-1:0];
  end

  assign bus.evt_cnt = cnt_q;
`else
  assign bus.evt_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Randomised bench for edge_pulse_gen: four configurations share one stimulus stream and are
// compared every cycle against a timestamp-based reference model.
module tb_edge_pulse_gen;

  localparam int NI   = 4;
  localparam int CHN  = 4;
  localparam int NCYC = 4000;

  localparam int SYNC_P  [NI] = '{2, 0, 3, 1};
  localparam int LEN_P   [NI] = '{4, 2, 1, 1};
  localparam int MEALY_P [NI] = '{0, 1, 0, 1};
  localparam int CNTW_P  [NI] = '{16, 4, 3, 16};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [CHN-1:0] in_v;
  logic [1:0]     mode_v;
  logic           retrig_v;
  logic           clr_v;

  edge_pulse_gen_if #(.CH(CHN), .CNT_W(CNTW_P[0])) if0 ();
  edge_pulse_gen_if #(.CH(CHN), .CNT_W(CNTW_P[1])) if1 ();
  edge_pulse_gen_if #(.CH(CHN), .CNT_W(CNTW_P[2])) if2 ();
  edge_pulse_gen_if #(.CH(CHN), .CNT_W(CNTW_P[3])) if3 ();

  assign if0.in = in_v;  assign if0.mode = mode_v;  assign if0.retrig = retrig_v;
  assign if0.clr = clr_v;
  assign if1.in = in_v;  assign if1.mode = mode_v;  assign if1.retrig = retrig_v;
  assign if1.clr = clr_v;
  assign if2.in = in_v;  assign if2.mode = mode_v;  assign if2.retrig = retrig_v;
  assign if2.clr = clr_v;
  assign if3.in = in_v;  assign if3.mode = mode_v;  assign if3.retrig = retrig_v;
  assign if3.clr = clr_v;

  edge_pulse_gen #(.CH(CHN), .SYNC_STAGES(SYNC_P[0]), .PULSE_LEN(LEN_P[0]),
                   .MEALY(MEALY_P[0]), .CNT_W(CNTW_P[0])) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  edge_pulse_gen #(.CH(CHN), .SYNC_STAGES(SYNC_P[1]), .PULSE_LEN(LEN_P[1]),
                   .MEALY(MEALY_P[1]), .CNT_W(CNTW_P[1])) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  edge_pulse_gen #(.CH(CHN), .SYNC_STAGES(SYNC_P[2]), .PULSE_LEN(LEN_P[2]),
                   .MEALY(MEALY_P[2]), .CNT_W(CNTW_P[2])) u_dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave));
  edge_pulse_gen #(.CH(CHN), .SYNC_STAGES(SYNC_P[3]), .PULSE_LEN(LEN_P[3]),
                   .MEALY(MEALY_P[3]), .CNT_W(CNTW_P[3])) u_dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave));

  logic [CHN-1:0] pulse_obs  [NI];
  logic [CHN-1:0] missed_obs [NI];
  logic [31:0]    cnt_obs    [NI];

  always_comb begin
    pulse_obs[0] = if0.pulse;  missed_obs[0] = if0.missed;  cnt_obs[0] = 32'(if0.evt_cnt);
    pulse_obs[1] = if1.pulse;  missed_obs[1] = if1.missed;  cnt_obs[1] = 32'(if1.evt_cnt);
    pulse_obs[2] = if2.pulse;  missed_obs[2] = if2.missed;  cnt_obs[2] = 32'(if2.evt_cnt);
    pulse_obs[3] = if3.pulse;  missed_obs[3] = if3.missed;  cnt_obs[3] = 32'(if3.evt_cnt);
  end

  // Reference model: input history plus, per channel, the last cycle its pulse is scheduled high.
  logic [CHN-1:0] hist [NCYC];
  int             since;
  int             busy_until [NI][CHN];
  logic [CHN-1:0] miss_m [NI];
  int             cnt_m  [NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronised level seen at cycle t, given the number of clean cycles since reset.
  function automatic logic s_at(input int k, input int sn, input int t, input int ch);
    if (sn >= k) return hist[t-k][ch];
    return 1'b0;
  endfunction

  initial begin
    in_v     = '0;
    mode_v   = 2'b00;
    retrig_v = 1'b0;
    clr_v    = 1'b0;
    since    = 0;
    for (int n = 0; n < NI; n++) begin
      miss_m[n] = '0;
      cnt_m[n]  = 0;
      for (int c = 0; c < CHN; c++) busy_until[n][c] = -100;
    end
    @(posedge clk);
    #1;

    for (int t = 0; t < NCYC; t++) begin
      reset = (t < 3) || ($urandom_range(249) == 0);
      for (int c = 0; c < CHN; c++) if ($urandom_range(5) == 0) in_v[c] = ~in_v[c];
      if ($urandom_range(39) == 0) mode_v = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) retrig_v = ~retrig_v;
      clr_v = ($urandom_range(24) == 0);
      hist[t] = in_v;

      @(negedge clk);
      for (int n = 0; n < NI; n++) begin
        logic [CHN-1:0] pulse_exp;
        logic [CHN-1:0] miss_set;
        int             ecount;
        int             cmax;
        int             exp_cnt;
        pulse_exp = '0;
        miss_set  = '0;
        ecount    = 0;
        for (int c = 0; c < CHN; c++) begin
          logic sv, pv, e, active;
          sv = s_at(SYNC_P[n], since, t, c);
          pv = (since >= 1) ? s_at(SYNC_P[n], since - 1, t - 1, c) : 1'b0;
          case (mode_v)
            2'b00:   e = sv && !pv;
            2'b01:   e = !sv && pv;
            2'b10:   e = sv != pv;
            default: e = 1'b0;
          endcase
          if (reset) e = 1'b0;
          active = (t <= busy_until[n][c]);
          if (e) begin
            ecount++;
            if (!active || retrig_v) busy_until[n][c] = t + LEN_P[n] - MEALY_P[n];
            else miss_set[c] = 1'b1;
          end
          pulse_exp[c] = (MEALY_P[n] != 0) ? (t <= busy_until[n][c]) : active;
        end

`ifdef EPG_EVT_CNT_EN
        exp_cnt = cnt_m[n];
`else
        exp_cnt = 0;
`endif
        check_eq($sformatf("pulse dut%0d t=%0d", n, t), 32'(pulse_obs[n]), 32'(pulse_exp));
        check_eq($sformatf("missed dut%0d t=%0d", n, t), 32'(missed_obs[n]), 32'(miss_m[n]));
        check_eq($sformatf("evt_cnt dut%0d t=%0d", n, t), cnt_obs[n], 32'(exp_cnt));

        cmax = (1 << CNTW_P[n]) - 1;
        if (reset) begin
          miss_m[n] = '0;
          cnt_m[n]  = 0;
          for (int c = 0; c < CHN; c++) busy_until[n][c] = -100;
        end else begin
          miss_m[n] = (clr_v ? '0 : miss_m[n]) | miss_set;
          cnt_m[n]  = (clr_v ? 0 : cnt_m[n]) + ecount;
          if (cnt_m[n] > cmax) cnt_m[n] = cmax;
        end
      end
      since = reset ? 0 : since + 1;

      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
